// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: hazard-control FSM state encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hzd_state_t;

endpackage

// File: rtl/fwd_select.sv
// Priority one-hot forwarding picker for one operand; source 0 (youngest) wins.
module fwd_select #(
  parameter int unsigned NSRC   = 2,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0]      addr,
  input  logic [NSRC-1:0]        wen,
  input  logic [NSRC*REG_AW-1:0] waddr,
  input  logic [NSRC-1:0]        lui,
  output logic [NSRC-1:0]        sel,
  output logic                   sel_lui
);

  logic found;

  always_comb begin
    sel     = '0;
    sel_lui = 1'b0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!found && (addr != '0) && wen[i] && (waddr[i*REG_AW +: REG_AW] == addr)) begin
        sel[i]  = 1'b1;
        sel_lui = lui[i];
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: operand forwarding, load-use bubbles, halt drain
// and saturating stall/flush counters.
module hazard_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_AW          = 5,
  parameter int unsigned NSRC            = 2,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned STALL_MODE      = 1,
  parameter int unsigned DRAIN_CYCLES    = NSRC + 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   dmem_req,
  input  logic [REG_AW-1:0]      rs_ex,
  input  logic [REG_AW-1:0]      rt_ex,
  input  logic [REG_AW-1:0]      rs_id,
  input  logic [REG_AW-1:0]      rt_id,
  input  logic                   memren_ex,
  input  logic                   memwen_ex,
  input  logic [REG_AW-1:0]      dest_ex,
  input  logic [NSRC-1:0]        src_wen,
  input  logic [NSRC*REG_AW-1:0] src_waddr,
  input  logic [NSRC-1:0]        src_lui,
  input  logic                   branch_taken,
  input  logic                   halt_id,
  output logic [NSRC-1:0]        fwd_a_sel,
  output logic [NSRC-1:0]        fwd_b_sel,
  output logic                   fwd_a_lui,
  output logic                   fwd_b_lui,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   flush_exmem,
  output logic                   halted,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam int unsigned CMAX    = (LOAD_USE_CYCLES > DRAIN_CYCLES) ? LOAD_USE_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CW      = $clog2(CMAX + 1);
  localparam int unsigned LU_INIT = (LOAD_USE_CYCLES > 1) ? LOAD_USE_CYCLES - 2 : 0;
  localparam int unsigned DR_INIT = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  hzd_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          dstall, adv, lu;
  logic          stall_inc, flush_inc;

  fwd_select #(.NSRC(NSRC), .REG_AW(REG_AW)) u_fwd_a (
    .addr(rs_ex), .wen(src_wen), .waddr(src_waddr), .lui(src_lui),
    .sel(fwd_a_sel), .sel_lui(fwd_a_lui)
  );

  fwd_select #(.NSRC(NSRC), .REG_AW(REG_AW)) u_fwd_b (
    .addr(rt_ex), .wen(src_wen), .waddr(src_waddr), .lui(src_lui),
    .sel(fwd_b_sel), .sel_lui(fwd_b_lui)
  );

  assign dstall = dmem_req & ~dhit;
  assign adv    = ihit & ~dstall;

  always_comb begin
    if (STALL_MODE != 0)
      lu = memren_ex && (dest_ex != '0) && ((dest_ex == rs_id) || (dest_ex == rt_id));
    else
      lu = memren_ex | memwen_ex;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pc_en       = adv;
    ifid_en     = adv;
    idex_en     = adv;
    exmem_en    = adv;
    memwb_en    = adv | dhit;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    halted      = 1'b0;
    flush_inc   = 1'b0;

    case (state)
      RUN: begin
        if (adv) begin
          if (branch_taken) begin
            {flush_ifid, flush_idex, flush_exmem} = 3'b111;
            flush_inc = 1'b1;
          end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_idex = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_nx = LU_STALL;
              cnt_nx   = CW'(LU_INIT);
            end
          end else if (halt_id) begin
            state_nx = DRAIN;
            cnt_nx   = CW'(DR_INIT);
          end
        end
      end
      // LU_STALL and DRAIN hold the front end; bubbles only enter while advancing.
      LU_STALL, DRAIN: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        if (adv) begin
          if (branch_taken) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            {flush_ifid, flush_idex, flush_exmem} = 3'b111;
            flush_inc = 1'b1;
            state_nx  = RUN;
            cnt_nx    = '0;
          end else begin
            flush_idex = 1'b1;
            if (cnt == '0)
              state_nx = (state == DRAIN) ? HALTED : RUN;
            else
              cnt_nx = cnt - 1'b1;
          end
        end
      end
      HALTED: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        halted   = 1'b1;
      end
      default: state_nx = RUN;
    endcase

    stall_inc = (state != HALTED) && (!adv || !pc_en);

    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      halted      = 1'b0;
      flush_inc   = 1'b0;
      stall_inc   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three configurations share one stimulus stream.
module tb_hazard_ctrl_unit;

  logic CLK, RST;
  logic ihit, dhit, dmem_req;
  logic [4:0] rs_ex, rt_ex, rs_id, rt_id, dest_ex;
  logic memren_ex, memwen_ex, branch_taken, halt_id;
  logic [2:0] src_wen, src_lui;
  logic [14:0] src_waddr;

  // u_p: NSRC=3, 3 load-use bubbles, precise; DRAIN_CYCLES=4
  logic [2:0] p_a_sel, p_b_sel;
  logic p_a_lui, p_b_lui, p_pc, p_ifid, p_idex, p_exmem, p_memwb;
  logic p_fifid, p_fidex, p_fexmem, p_halted;
  logic [31:0] p_scnt, p_fcnt;
  // u_d: defaults (NSRC=2, 1 bubble, precise, DRAIN_CYCLES=3)
  logic [1:0] d_a_sel, d_b_sel;
  logic d_a_lui, d_b_lui, d_pc, d_ifid, d_idex, d_exmem, d_memwb;
  logic d_fifid, d_fidex, d_fexmem, d_halted;
  logic [31:0] d_scnt, d_fcnt;
  // u_c: conservative stall mode
  logic [1:0] c_a_sel, c_b_sel;
  logic c_a_lui, c_b_lui, c_pc, c_ifid, c_idex, c_exmem, c_memwb;
  logic c_fifid, c_fidex, c_fexmem, c_halted;
  logic [31:0] c_scnt, c_fcnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit #(.NSRC(3), .LOAD_USE_CYCLES(3), .STALL_MODE(1)) u_p (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .memren_ex(memren_ex), .memwen_ex(memwen_ex), .dest_ex(dest_ex),
    .src_wen(src_wen), .src_waddr(src_waddr), .src_lui(src_lui),
    .branch_taken(branch_taken), .halt_id(halt_id),
    .fwd_a_sel(p_a_sel), .fwd_b_sel(p_b_sel), .fwd_a_lui(p_a_lui), .fwd_b_lui(p_b_lui),
    .pc_en(p_pc), .ifid_en(p_ifid), .idex_en(p_idex), .exmem_en(p_exmem), .memwb_en(p_memwb),
    .flush_ifid(p_fifid), .flush_idex(p_fidex), .flush_exmem(p_fexmem),
    .halted(p_halted), .stall_cnt(p_scnt), .flush_cnt(p_fcnt)
  );

  hazard_ctrl_unit #(.NSRC(2)) u_d (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .memren_ex(memren_ex), .memwen_ex(memwen_ex), .dest_ex(dest_ex),
    .src_wen(src_wen[1:0]), .src_waddr(src_waddr[9:0]), .src_lui(src_lui[1:0]),
    .branch_taken(branch_taken), .halt_id(halt_id),
    .fwd_a_sel(d_a_sel), .fwd_b_sel(d_b_sel), .fwd_a_lui(d_a_lui), .fwd_b_lui(d_b_lui),
    .pc_en(d_pc), .ifid_en(d_ifid), .idex_en(d_idex), .exmem_en(d_exmem), .memwb_en(d_memwb),
    .flush_ifid(d_fifid), .flush_idex(d_fidex), .flush_exmem(d_fexmem),
    .halted(d_halted), .stall_cnt(d_scnt), .flush_cnt(d_fcnt)
  );

  hazard_ctrl_unit #(.NSRC(2), .STALL_MODE(0)) u_c (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .memren_ex(memren_ex), .memwen_ex(memwen_ex), .dest_ex(dest_ex),
    .src_wen(src_wen[1:0]), .src_waddr(src_waddr[9:0]), .src_lui(src_lui[1:0]),
    .branch_taken(branch_taken), .halt_id(halt_id),
    .fwd_a_sel(c_a_sel), .fwd_b_sel(c_b_sel), .fwd_a_lui(c_a_lui), .fwd_b_lui(c_b_lui),
    .pc_en(c_pc), .ifid_en(c_ifid), .idex_en(c_idex), .exmem_en(c_exmem), .memwb_en(c_memwb),
    .flush_ifid(c_fifid), .flush_idex(c_fidex), .flush_exmem(c_fexmem),
    .halted(c_halted), .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
  );

  logic [4:0] p_en, d_en;
  logic [2:0] p_fl, d_fl;
  assign p_en = {p_pc, p_ifid, p_idex, p_exmem, p_memwb};
  assign d_en = {d_pc, d_ifid, d_idex, d_exmem, d_memwb};
  assign p_fl = {p_fifid, p_fidex, p_fexmem};
  assign d_fl = {d_fifid, d_fidex, d_fexmem};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [2:0]  wen;
    logic [14:0] waddr;
    logic [2:0]  lui;
    logic        ih, dh, dm, br;
    logic [2:0]  a_sel, b_sel;
    logic [1:0]  luis;
    logic [4:0]  en;
    logic [2:0]  fl;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] wen,
                               input logic [14:0] waddr, input logic [2:0] lui,
                               input logic ih, input logic dh, input logic dm, input logic br,
                               input logic [2:0] a_sel, input logic [2:0] b_sel,
                               input logic [1:0] luis, input logic [4:0] en, input logic [2:0] fl);
    vec_t v;
    v.rs = rs; v.rt = rt; v.wen = wen; v.waddr = waddr; v.lui = lui;
    v.ih = ih; v.dh = dh; v.dm = dm; v.br = br;
    v.a_sel = a_sel; v.b_sel = b_sel; v.luis = luis; v.en = en; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b0;
    rs_ex = '0; rt_ex = '0; rs_id = '0; rt_id = '0; dest_ex = '0;
    memren_ex = 1'b0; memwen_ex = 1'b0; branch_taken = 1'b0; halt_id = 1'b0;
    src_wen = '0; src_waddr = '0; src_lui = '0;
  endtask

  task automatic reset_all();
    RST = 1'b1;
    idle();
    tick();
    tick();
    RST = 1'b0;
  endtask

  int bub;

  initial begin
    RST = 1'b1;
    idle();

    // src waddr packed as {src2, src1, src0}
    vecs[0] = mkv(5'd5,  5'd0,  3'b111, {5'd5, 5'd7, 5'd5},  3'b000, 1,1,0,0, 3'b001, 3'b000, 2'b00, 5'b11111, 3'b000);
    vecs[1] = mkv(5'd5,  5'd7,  3'b110, {5'd5, 5'd7, 5'd5},  3'b010, 1,1,0,0, 3'b100, 3'b010, 2'b01, 5'b11111, 3'b000);
    vecs[2] = mkv(5'd0,  5'd0,  3'b111, {5'd0, 5'd0, 5'd0},  3'b111, 1,1,0,0, 3'b000, 3'b000, 2'b00, 5'b11111, 3'b000);
    vecs[3] = mkv(5'd3,  5'd3,  3'b111, {5'd3, 5'd3, 5'd4},  3'b100, 1,1,0,0, 3'b010, 3'b010, 2'b00, 5'b11111, 3'b000);
    vecs[4] = mkv(5'd9,  5'd3,  3'b101, {5'd3, 5'd3, 5'd9},  3'b101, 1,1,0,0, 3'b001, 3'b100, 2'b11, 5'b11111, 3'b000);
    vecs[5] = mkv(5'd31, 5'd31, 3'b001, {5'd0, 5'd0, 5'd31}, 3'b000, 0,1,0,0, 3'b001, 3'b001, 2'b00, 5'b00001, 3'b000);
    vecs[6] = mkv(5'd1,  5'd2,  3'b000, {5'd1, 5'd2, 5'd1},  3'b000, 1,0,1,0, 3'b000, 3'b000, 2'b00, 5'b00000, 3'b000);
    vecs[7] = mkv(5'd1,  5'd2,  3'b011, {5'd0, 5'd2, 5'd1},  3'b011, 1,1,1,0, 3'b001, 3'b010, 2'b11, 5'b11111, 3'b000);
    vecs[8] = mkv(5'd4,  5'd6,  3'b100, {5'd6, 5'd0, 5'd0},  3'b000, 1,1,0,1, 3'b000, 3'b100, 2'b00, 5'b11111, 3'b111);
    vecs[9] = mkv(5'd4,  5'd6,  3'b000, {5'd6, 5'd0, 5'd0},  3'b000, 0,1,0,1, 3'b000, 3'b000, 2'b00, 5'b00001, 3'b000);

    // Reset state
    tick();
    tick();
    @(negedge CLK);
    chk("rst_en", {27'd0, p_en}, 32'd0);
    chk("rst_fl", {29'd0, p_fl}, 32'd0);
    chk("rst_halted", {31'd0, p_halted}, 32'd0);
    chk("rst_scnt", p_scnt, 32'd0);
    chk("rst_fcnt", p_fcnt, 32'd0);
    tick();
    RST = 1'b0;

    // Table: forwarding and default enables in RUN
    for (int i = 0; i < 10; i++) begin
      rs_ex = vecs[i].rs; rt_ex = vecs[i].rt;
      src_wen = vecs[i].wen; src_waddr = vecs[i].waddr; src_lui = vecs[i].lui;
      ihit = vecs[i].ih; dhit = vecs[i].dh; dmem_req = vecs[i].dm; branch_taken = vecs[i].br;
      @(negedge CLK);
      chk($sformatf("v%0d_a_sel", i), {29'd0, p_a_sel}, {29'd0, vecs[i].a_sel});
      chk($sformatf("v%0d_b_sel", i), {29'd0, p_b_sel}, {29'd0, vecs[i].b_sel});
      chk($sformatf("v%0d_lui", i), {30'd0, p_a_lui, p_b_lui}, {30'd0, vecs[i].luis});
      chk($sformatf("v%0d_en", i), {27'd0, p_en}, {27'd0, vecs[i].en});
      chk($sformatf("v%0d_fl", i), {29'd0, p_fl}, {29'd0, vecs[i].fl});
      tick();
    end
    @(negedge CLK);
    chk("tbl_scnt", p_scnt, 32'd3);
    chk("tbl_fcnt", p_fcnt, 32'd1);

    // Load-use: 1 bubble on u_d, 3 bubbles on u_p with a 2-cycle ihit gap
    reset_all();
    memren_ex = 1'b1; dest_ex = 5'd8; rs_id = 5'd8;
    bub = 0;
    @(negedge CLK);
    chk("lu_d_pc0", {31'd0, d_pc}, 32'd0);
    chk("lu_d_fidex0", {31'd0, d_fidex}, 32'd1);
    chk("lu_p_pc0", {31'd0, p_pc}, 32'd0);
    bub += int'(p_fidex & p_idex);
    tick();
    memren_ex = 1'b0;
    @(negedge CLK);
    chk("lu_d_pc1", {31'd0, d_pc}, 32'd1);
    chk("lu_d_fidex1", {31'd0, d_fidex}, 32'd0);
    chk("lu_p_pc1", {31'd0, p_pc}, 32'd0);
    bub += int'(p_fidex & p_idex);
    tick();
    ihit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      bub += int'(p_fidex & p_idex);
      tick();
    end
    ihit = 1'b1;
    @(negedge CLK);
    chk("lu_p_pc4", {31'd0, p_pc}, 32'd0);
    bub += int'(p_fidex & p_idex);
    tick();
    @(negedge CLK);
    chk("lu_p_pc5", {31'd0, p_pc}, 32'd1);
    chk("lu_p_fidex5", {31'd0, p_fidex}, 32'd0);
    chk("lu_p_bubbles", bub, 32'd3);
    chk("lu_p_scnt", p_scnt, 32'd5);
    chk("lu_d_scnt", d_scnt, 32'd3);
    tick();
    memren_ex = 1'b1; dest_ex = 5'd8; rs_id = 5'd9;
    @(negedge CLK);
    chk("nodep_d_pc", {31'd0, d_pc}, 32'd1);
    chk("nodep_d_fidex", {31'd0, d_fidex}, 32'd0);
    chk("cons_ld_c_pc", {31'd0, c_pc}, 32'd0);
    chk("cons_ld_c_fidex", {31'd0, c_fidex}, 32'd1);
    tick();
    memren_ex = 1'b0; memwen_ex = 1'b1;
    @(negedge CLK);
    chk("cons_sw_c_pc", {31'd0, c_pc}, 32'd0);
    chk("cons_sw_d_pc", {31'd0, d_pc}, 32'd1);
    tick();

    // Branch preempts LU_STALL
    reset_all();
    memren_ex = 1'b1; dest_ex = 5'd8; rs_id = 5'd8;
    tick();
    branch_taken = 1'b1;
    @(negedge CLK);
    chk("lubr_p_fl", {29'd0, p_fl}, 32'd7);
    chk("lubr_p_pc", {31'd0, p_pc}, 32'd1);
    tick();
    branch_taken = 1'b0; memren_ex = 1'b0;
    @(negedge CLK);
    chk("lubr_p_fl_after", {29'd0, p_fl}, 32'd0);
    chk("lubr_p_pc_after", {31'd0, p_pc}, 32'd1);
    chk("lubr_p_fcnt", p_fcnt, 32'd1);
    tick();

    // Halt drain to HALTED, then reset out of it
    reset_all();
    halt_id = 1'b1;
    @(negedge CLK);
    chk("halt_d_pc", {31'd0, d_pc}, 32'd1);
    tick();
    halt_id = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("drain%0d_d_en", k), {27'd0, d_en}, 32'b00111);
      chk($sformatf("drain%0d_d_fl", k), {29'd0, d_fl}, 32'b010);
      chk($sformatf("drain%0d_d_halted", k), {31'd0, d_halted}, 32'd0);
      tick();
    end
    @(negedge CLK);
    chk("halted_d", {31'd0, d_halted}, 32'd1);
    chk("halted_d_en", {27'd0, d_en}, 32'd0);
    chk("halted_d_fl", {29'd0, d_fl}, 32'd0);
    chk("halted_p_not_yet", {31'd0, p_halted}, 32'd0);
    chk("halted_d_scnt", d_scnt, 32'd3);
    tick();
    @(negedge CLK);
    chk("halted_p", {31'd0, p_halted}, 32'd1);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("hrst_d_halted", {31'd0, d_halted}, 32'd0);
    chk("hrst_d_en", {27'd0, d_en}, 32'd0);
    tick();
    @(negedge CLK);
    chk("hrst_d_scnt", d_scnt, 32'd0);
    chk("hrst_d_fcnt", d_fcnt, 32'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("hrel_d_halted", {31'd0, d_halted}, 32'd0);
    chk("hrel_d_en", {27'd0, d_en}, 32'b11111);
    tick();

    // Branch during DRAIN squashes the halt
    reset_all();
    halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    tick();
    branch_taken = 1'b1;
    @(negedge CLK);
    chk("drbr_d_fl", {29'd0, d_fl}, 32'd7);
    tick();
    branch_taken = 1'b0;
    repeat (5) tick();
    @(negedge CLK);
    chk("drbr_d_halted", {31'd0, d_halted}, 32'd0);
    chk("drbr_d_pc", {31'd0, d_pc}, 32'd1);
    chk("drbr_d_fcnt", d_fcnt, 32'd1);
    tick();

    // Data-memory stall
    reset_all();
    dmem_req = 1'b1; dhit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("dst%0d_exmem", k), {31'd0, d_exmem}, 32'd0);
      chk($sformatf("dst%0d_memwb", k), {31'd0, d_memwb}, 32'd0);
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    chk("dhit_memwb", {31'd0, d_memwb}, 32'd1);
    chk("dhit_exmem", {31'd0, d_exmem}, 32'd1);
    chk("dst_scnt", d_scnt, 32'd4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
